// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder; the ovf wire exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;

    modport master (output start, a, b, cin, input busy, done, sum, carry, ovf);
    modport slave  (input start, a, b, cin, output busy, done, sum, carry, ovf);
`else
    modport master (output start, a, b, cin, input busy, done, sum, carry);
    modport slave  (input start, a, b, cin, output busy, done, sum, carry);
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus carry flop, LSB first, one bit per clock.
// Optional signed-overflow output enabled by SERIAL_ADDER_OVF_EN.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);
    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_a_sh, w_a_sh_nxt;
    logic [WIDTH-1:0] r_b_sh, w_b_sh_nxt;
    logic [WIDTH-1:0] r_res_sh, w_res_sh_nxt;
    logic             r_cf, w_cf_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_sum, w_sum_nxt;
    logic             r_carry, w_carry_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
`ifdef SERIAL_ADDER_OVF_EN
    logic             r_ovf, w_ovf_nxt;
`endif

    logic             w_fa_sum;
    logic             w_fa_co;
    logic [WIDTH-1:0] w_res_shift;

    // The single full-adder cell and the result shift (new bit enters at the MSB).
    assign w_fa_sum    = r_a_sh[0] ^ r_b_sh[0] ^ r_cf;
    assign w_fa_co     = (r_a_sh[0] & r_b_sh[0]) | (r_a_sh[0] & r_cf) | (r_b_sh[0] & r_cf);
    assign w_res_shift = (r_res_sh >> 1) | (WIDTH'(w_fa_sum) << (WIDTH - 1));

    always_comb begin
        w_state_nxt  = r_state;
        w_a_sh_nxt   = r_a_sh;
        w_b_sh_nxt   = r_b_sh;
        w_res_sh_nxt = r_res_sh;
        w_cf_nxt     = r_cf;
        w_cnt_nxt    = r_cnt;
        w_sum_nxt    = r_sum;
        w_carry_nxt  = r_carry;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
        w_ovf_nxt    = r_ovf;
`endif
        case (r_state)
            IDLE, DONE: begin
                // DONE always leaves after one cycle; a start here chains straight into the next add.
                if (r_state == DONE) w_state_nxt = IDLE;
                if (bus.start) begin
                    w_state_nxt = SHIFT;
                    w_a_sh_nxt  = bus.a;
                    w_b_sh_nxt  = bus.b;
                    w_cf_nxt    = bus.cin;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                end
            end
            SHIFT: begin
                w_a_sh_nxt   = r_a_sh >> 1;
                w_b_sh_nxt   = r_b_sh >> 1;
                w_cf_nxt     = w_fa_co;
                w_res_sh_nxt = w_res_shift;
                w_cnt_nxt    = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_state_nxt = DONE;
                    w_sum_nxt   = w_res_shift;
                    w_carry_nxt = w_fa_co;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
                    // r_cf is the carry into the MSB, w_fa_co the carry out of it.
                    w_ovf_nxt   = r_cf ^ w_fa_co;
`endif
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_cf     <= 1'b0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_carry  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf    <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_a_sh   <= w_a_sh_nxt;
            r_b_sh   <= w_b_sh_nxt;
            r_res_sh <= w_res_sh_nxt;
            r_cf     <= w_cf_nxt;
            r_cnt    <= w_cnt_nxt;
            r_sum    <= w_sum_nxt;
            r_carry  <= w_carry_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf    <= w_ovf_nxt;
`endif
        end
    end

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.sum   = r_sum;
    assign bus.carry = r_carry;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf   = r_ovf;
`endif
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial multi-bit adder built around one full-adder cell (sum = a^b^c, carry = majority) plus a registered carry.
- Consumes two WIDTH-bit operands and a carry-in, processes one bit per clock (LSB first) and presents a WIDTH-bit sum and a carry-out.
- Sits directly downstream of the operand source and upstream of the result consumer.
- Trades latency for area versus a ripple chain of full adders.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk    input   1      rising-edge clock
- rst    input   1      synchronous, active-high reset
- start  input   1      request; sampled only when busy=0
- a      input   WIDTH  operand A; sampled on the accepted start edge only
- b      input   WIDTH  operand B; sampled on the accepted start edge only
- cin    input   1      carry-in; sampled on the accepted start edge only
- busy   output  1      high while an addition is in progress
- done   output  1      one-cycle pulse: result valid
- sum    output  WIDTH  registered sum; held until the next accepted start
- carry  output  1      registered carry-out; held until the next accepted start
- ovf    output  1      present only with SERIAL_ADDER_OVF_EN (see Optional Feature)

Behaviour:
- One clock domain (clk). rst is synchronous and active-high; it is sampled only on the rising clk edge.
- Reset values: busy=0, done=0, sum=0, carry=0, ovf=0. The FSM enters IDLE and the bit counter clears. Internal shift registers and the carry flop clear.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: start=1 loads a and b into shift registers, loads cin into the carry flop, clears the bit counter, and moves to SHIFT. busy goes high on the same edge.
  - SHIFT: each edge performs one full-add on the shift-register LSBs and the carry flop. The sum bit shifts into the result register from the MSB side. The carry flop updates and the counter increments. On the edge where counter = WIDTH-1, sum and carry are written to the outputs, done is set, busy clears, and the FSM moves to DONE.
  - DONE: lasts exactly one cycle, with done=1. On the next edge done clears. If start=1 on that edge, it is accepted exactly as in IDLE (back-to-back operation). Otherwise the FSM goes to IDLE.
- Latency: start accepted at edge N; done is high during the cycle after edge N+WIDTH. For WIDTH=8 that is 8 edges after acceptance.
- Throughput: one addition every WIDTH+1 cycles.
- start while busy=1 is ignored. It does not restart the operation, and a, b and cin changes have no effect mid-operation.
- sum and carry do not change during SHIFT. They update only on the completing edge, so the previous result stays visible while busy.
- Arithmetic: {carry, sum} = a + b + cin, with unsigned wrap modulo 2^WIDTH. The carry-out is the final carry flop value.
- Reset mid-operation aborts the addition. All outputs return to their reset values on that edge, and no done pulse is produced.
- rst=1 together with start=1: rst wins and start is dropped.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN
- Defined:
  - Port ovf exists.
  - ovf = carry into the MSB XOR carry out of the MSB, i.e. signed two's-complement overflow.
  - Captured on the completing edge alongside sum; held until the next accepted start; reset to 0.
- Undefined:
  - No ovf port.
  - No MSB-carry tracking logic.
  - All other behaviour identical.

Test Plan:
- WIDTH=8, a=8'h0F, b=8'h01, cin=0, start pulse -> busy high for 8 cycles; done one-cycle pulse 8 edges after acceptance; sum=8'h10, carry=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, carry=1, ovf=0 (macro on). Then a=8'h7F, b=8'h00, cin=1 -> sum=8'h80, carry=0, ovf=1.
- Start accepted with a=8'h12, b=8'h34, cin=0. Three cycles later, start=1 with a=8'hFF, b=8'hFF -> ignored; result sum=8'h46, carry=0, at the original latency.
- Start held high across the done cycle with new operands a=8'hAA, b=8'h55, cin=1 -> second op accepted on the DONE-exit edge; first result sum=8'h46 visible until the second completes with sum=8'h00, carry=1.
- rst asserted 4 cycles into an operation -> next edge busy=0, done=0, sum=0, carry=0; no done pulse follows. A subsequent start of 8'h01+8'h01 completes normally with sum=8'h02.
